// File: rtl/yarvi_trace_buf_if.sv
`default_nettype none
// ============================================================================
//  Module   : yarvi_trace_buf_if
//  Brief    : Commit-stream input, trigger control and replay output bundle
//             for the retire-trace capture buffer.
//  Revision : 1.0 - initial release
// ============================================================================
`ifndef VMSB
`define VMSB 31
`endif

interface yarvi_trace_buf_if #(
   parameter int DEPTH_LOG2 = 4
) ();
   // trigger / control
   logic                  arm;
   logic                  trig_ext;
   logic                  trig_pc_en;
   logic [`VMSB:0]        trig_pc;
   logic [1:0]            min_prv;
   // commit stream
   logic                  in_valid;
   logic [1:0]            in_prv;
   logic [`VMSB:0]        in_pc;
   logic [31:0]           in_insn;
   logic [4:0]            in_wb_rd;
   logic [`VMSB:0]        in_wb_val;
   // replay towards the disassembler
   logic                  valid;
   logic [1:0]            prv;
   logic [`VMSB:0]        pc;
   logic [31:0]           insn;
   logic [4:0]            wb_rd;
   logic [`VMSB:0]        wb_val;
   logic [3:0]            info;
   logic [1:0]            state;
   logic [DEPTH_LOG2:0]   count;

   modport master (
      output arm, trig_ext, trig_pc_en, trig_pc, min_prv,
      output in_valid, in_prv, in_pc, in_insn, in_wb_rd, in_wb_val,
      input  valid, prv, pc, insn, wb_rd, wb_val, info, state, count
   );

   modport slave (
      input  arm, trig_ext, trig_pc_en, trig_pc, min_prv,
      input  in_valid, in_prv, in_pc, in_insn, in_wb_rd, in_wb_val,
      output valid, prv, pc, insn, wb_rd, wb_val, info, state, count
   );
endinterface

`default_nettype wire

// File: rtl/yarvi_trace_buf.sv
`default_nettype none
// ============================================================================
//  Module   : yarvi_trace_buf
//  Brief    : Circular retire-trace buffer: records the last 2**DEPTH_LOG2
//             retirements, freezes POST retirements after a trigger and
//             replays the window oldest-first. Optional privilege filter
//             enabled by defining YARVI_TRACE_PRV_FILTER_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`ifndef VMSB
`define VMSB 31
`endif

module yarvi_trace_buf #(
   parameter int DEPTH_LOG2 = 4,
   parameter int POST       = 4
) (
   input  wire                clock,
   input  wire                reset_n,
   yarvi_trace_buf_if.slave   bus
);

   localparam int                  c_DEPTH = 1 << DEPTH_LOG2;
   localparam int                  c_XW    = `VMSB + 1;
   localparam logic [DEPTH_LOG2:0] c_FULL  = (DEPTH_LOG2+1)'(c_DEPTH);
   localparam logic [DEPTH_LOG2-1:0] c_POST = DEPTH_LOG2'(POST);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RECORD = 2'd1,
      S_POST   = 2'd2,
      S_DUMP   = 2'd3
   } state_t;

   typedef struct packed {
      logic            trig;
      logic [1:0]      prv;
      logic [c_XW-1:0] pc;
      logic [31:0]     insn;
      logic [4:0]      wb_rd;
      logic [c_XW-1:0] wb_val;
   } rec_t;

   rec_t                  mem_q [c_DEPTH];

   state_t                state_q,  state_d;
   logic [DEPTH_LOG2-1:0] wptr_q,   wptr_d;
   logic [DEPTH_LOG2-1:0] rptr_q,   rptr_d;
   logic [DEPTH_LOG2-1:0] post_q,   post_d;
   logic [DEPTH_LOG2:0]   count_q,  count_d;
   logic [DEPTH_LOG2:0]   rem_q,    rem_d;
   logic                  valid_q,  valid_d;
   logic                  last_q,   last_d;
   rec_t                  out_q,    out_d;

   logic                  w_trig;
   logic                  w_prv_ok;
   logic                  w_wr_en;
   rec_t                  w_wr_rec;
   rec_t                  w_rd_rec;
   logic [DEPTH_LOG2:0]   w_count_inc;

   assign w_trig = bus.in_valid &
                   (bus.trig_ext | (bus.trig_pc_en & (bus.in_pc == bus.trig_pc)));

`ifdef YARVI_TRACE_PRV_FILTER_EN
   assign w_prv_ok = (bus.in_prv >= bus.min_prv);
`else
   assign w_prv_ok = 1'b1;
   wire   w_unused_min_prv = ^bus.min_prv;
`endif

   assign w_count_inc = (count_q == c_FULL) ? count_q : count_q + 1'b1;
   assign w_rd_rec    = mem_q[rptr_q];

   always_comb begin
      state_d  = state_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      post_d   = post_q;
      count_d  = count_q;
      rem_d    = rem_q;
      valid_d  = 1'b0;
      last_d   = 1'b0;
      out_d    = '0;
      w_wr_en  = 1'b0;
      w_wr_rec = '{trig:   1'b0,
                   prv:    bus.in_prv,
                   pc:     bus.in_pc,
                   insn:   bus.in_insn,
                   wb_rd:  bus.in_wb_rd,
                   wb_val: bus.in_wb_val};

      case (state_q)
         S_IDLE: begin
            if (bus.arm) begin
               state_d = S_RECORD;
               wptr_d  = '0;
               count_d = '0;
            end
         end

         S_RECORD: begin
            // a triggering record is kept even if the filter would drop it
            if (bus.in_valid && (w_prv_ok || w_trig)) begin
               w_wr_en       = 1'b1;
               w_wr_rec.trig = w_trig;
               wptr_d        = wptr_q + 1'b1;
               count_d       = w_count_inc;
               if (w_trig) begin
                  if (POST == 0) begin
                     state_d = S_DUMP;
                  end else begin
                     state_d = S_POST;
                     post_d  = c_POST;
                  end
               end
            end
         end

         S_POST: begin
            if (bus.in_valid && w_prv_ok) begin
               w_wr_en = 1'b1;
               wptr_d  = wptr_q + 1'b1;
               count_d = w_count_inc;
               post_d  = post_q - 1'b1;
               if (post_q == DEPTH_LOG2'(1)) begin
                  state_d = S_DUMP;
               end
            end
         end

         S_DUMP: begin
            if (rem_q != '0) begin
               valid_d = 1'b1;
               out_d   = w_rd_rec;
               last_d  = (rem_q == (DEPTH_LOG2+1)'(1));
               rptr_d  = rptr_q + 1'b1;
               rem_d   = rem_q - 1'b1;
            end else begin
               state_d = S_IDLE;
               count_d = '0;
            end
         end

         default: state_d = S_IDLE;
      endcase

      // On the freeze edge the oldest record sits count entries behind
      // the write pointer; a full buffer wraps onto the write pointer.
      if ((state_d == S_DUMP) && (state_q != S_DUMP)) begin
         rptr_d = wptr_d - count_d[DEPTH_LOG2-1:0];
         rem_d  = count_d;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         post_q  <= '0;
         count_q <= '0;
         rem_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         post_q  <= post_d;
         count_q <= count_d;
         rem_q   <= rem_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         out_q   <= out_d;
      end
   end

   // Trace storage carries no reset; contents are meaningless until written.
   always_ff @(posedge clock) begin
      if (w_wr_en) begin
         mem_q[wptr_q] <= w_wr_rec;
      end
   end

   assign bus.valid  = valid_q;
   assign bus.prv    = out_q.prv;
   assign bus.pc     = out_q.pc;
   assign bus.insn   = out_q.insn;
   assign bus.wb_rd  = out_q.wb_rd;
   assign bus.wb_val = out_q.wb_val;
   assign bus.info   = {out_q.trig, last_q, 2'b00};
   assign bus.state  = state_q;
   assign bus.count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_yarvi_trace_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_yarvi_trace_buf
//  Brief    : Directed scoreboard bench for yarvi_trace_buf (POST=4 and POST=0).
//  Revision : 1.0 - initial release
// ============================================================================
`ifndef VMSB
`define VMSB 31
`endif

module tb_yarvi_trace_buf;

   localparam int XW = `VMSB + 1;

   typedef struct {
      logic [1:0]    prv;
      logic [XW-1:0] pc;
      logic [31:0]   insn;
      logic [4:0]    rd;
      logic [XW-1:0] val;
      logic [3:0]    info;
   } exp_t;

   logic clock = 1'b0;
   logic reset_n = 1'b1;
   always #5 clock = ~clock;

   logic          arm_a, arm_b, trig_ext, trig_pc_en, in_valid;
   logic [XW-1:0] trig_pc, in_pc, in_wb_val;
   logic [1:0]    in_prv, min_prv;
   logic [31:0]   in_insn;
   logic [4:0]    in_wb_rd;

   int n_vec = 0;
   int n_bad = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   yarvi_trace_buf_if #(.DEPTH_LOG2(4)) bus_a ();
   yarvi_trace_buf_if #(.DEPTH_LOG2(4)) bus_b ();

   assign bus_a.arm = arm_a;            assign bus_b.arm = arm_b;
   assign bus_a.trig_ext = trig_ext;    assign bus_b.trig_ext = trig_ext;
   assign bus_a.trig_pc_en = trig_pc_en; assign bus_b.trig_pc_en = trig_pc_en;
   assign bus_a.trig_pc = trig_pc;      assign bus_b.trig_pc = trig_pc;
   assign bus_a.min_prv = min_prv;      assign bus_b.min_prv = min_prv;
   assign bus_a.in_valid = in_valid;    assign bus_b.in_valid = in_valid;
   assign bus_a.in_prv = in_prv;        assign bus_b.in_prv = in_prv;
   assign bus_a.in_pc = in_pc;          assign bus_b.in_pc = in_pc;
   assign bus_a.in_insn = in_insn;      assign bus_b.in_insn = in_insn;
   assign bus_a.in_wb_rd = in_wb_rd;    assign bus_b.in_wb_rd = in_wb_rd;
   assign bus_a.in_wb_val = in_wb_val;  assign bus_b.in_wb_val = in_wb_val;

   yarvi_trace_buf #(.DEPTH_LOG2(4), .POST(4)) dut_a (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus_a)
   );

   yarvi_trace_buf #(.DEPTH_LOG2(4), .POST(0)) dut_b (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus_b)
   );

   function automatic logic [31:0] f_insn(input logic [XW-1:0] pc);
      return {pc[23:0], 8'h13};
   endfunction

   function automatic logic [4:0] f_rd(input logic [XW-1:0] pc);
      return pc[6:2];
   endfunction

   function automatic exp_t mk(input logic [XW-1:0] pc, input logic [1:0] prv,
                               input logic trig, input logic last);
      exp_t e;
      e.prv = prv; e.pc = pc; e.insn = f_insn(pc); e.rd = f_rd(pc);
      e.val = ~pc; e.info = {trig, last, 2'b00};
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, want);
      end
   endtask

   task automatic cmp_rec(input string nm, input exp_t e, input logic [1:0] prv,
                          input logic [XW-1:0] pc, input logic [31:0] insn,
                          input logic [4:0] rd, input logic [XW-1:0] val,
                          input logic [3:0] info);
      n_vec++;
      if (prv !== e.prv || pc !== e.pc || insn !== e.insn || rd !== e.rd ||
          val !== e.val || info !== e.info) begin
         n_bad++;
         $display("FAIL %s: got prv=%0d pc=%h insn=%h rd=%0d val=%h info=%b, expected prv=%0d pc=%h insn=%h rd=%0d val=%h info=%b",
                  nm, prv, pc, insn, rd, val, info, e.prv, e.pc, e.insn, e.rd, e.val, e.info);
      end
   endtask

   // Scoreboard monitors: every replayed record must match the queue head.
   always @(negedge clock) begin
      if (bus_a.valid === 1'b1) begin
         if (q_a.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL dump_a unexpected record pc=%h info=%b", bus_a.pc, bus_a.info);
         end else begin
            cmp_rec("dump_a", q_a.pop_front(), bus_a.prv, bus_a.pc, bus_a.insn,
                    bus_a.wb_rd, bus_a.wb_val, bus_a.info);
         end
      end
   end

   always @(negedge clock) begin
      if (bus_b.valid === 1'b1) begin
         if (q_b.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL dump_b unexpected record pc=%h info=%b", bus_b.pc, bus_b.info);
         end else begin
            cmp_rec("dump_b", q_b.pop_front(), bus_b.prv, bus_b.pc, bus_b.insn,
                    bus_b.wb_rd, bus_b.wb_val, bus_b.info);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic gap(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse_arm(input bit sel);
      if (sel) arm_b = 1'b1; else arm_a = 1'b1;
      tick();
      arm_a = 1'b0; arm_b = 1'b0;
   endtask

   task automatic retire(input logic [XW-1:0] pc, input logic [1:0] prv, input logic trig);
      in_valid = 1'b1; in_pc = pc; in_prv = prv; in_insn = f_insn(pc);
      in_wb_rd = f_rd(pc); in_wb_val = ~pc; trig_ext = trig;
      tick();
      in_valid = 1'b0; trig_ext = 1'b0;
   endtask

   // Bounded wait for the replay to drain back to IDLE.
   task automatic wait_idle(input string nm, input bit sel);
      for (int k = 0; k < 100; k++) begin
         if ((sel ? bus_b.state : bus_a.state) == 2'd0 &&
             (sel ? q_b.size() : q_a.size()) == 0) break;
         tick();
      end
      chk({nm, "_state_idle"}, 64'(sel ? bus_b.state : bus_a.state), 64'd0);
      chk({nm, "_count_zero"}, 64'(sel ? bus_b.count : bus_a.count), 64'd0);
      chk({nm, "_drained"}, 64'(sel ? q_b.size() : q_a.size()), 64'd0);
      chk({nm, "_valid_low"}, 64'(sel ? bus_b.valid : bus_a.valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] fprv [10];
      fprv = '{2'd3, 2'd0, 2'd3, 2'd0, 2'd0, 2'd3, 2'd0, 2'd3, 2'd3, 2'd3};
      arm_a = 0; arm_b = 0; trig_ext = 0; trig_pc_en = 0; trig_pc = '0;
      min_prv = 2'd0; in_valid = 0; in_pc = '0; in_prv = '0; in_insn = '0;
      in_wb_rd = '0; in_wb_val = '0;

      // ---- reset state
      #2 reset_n = 1'b0;
      gap(3);
      chk("rst_valid", 64'(bus_a.valid), 64'd0);
      chk("rst_state", 64'(bus_a.state), 64'd0);
      chk("rst_count", 64'(bus_a.count), 64'd0);
      chk("rst_pc",    64'(bus_a.pc),    64'd0);
      chk("rst_info",  64'(bus_a.info),  64'd0);
      chk("rst_state_b", 64'(bus_b.state), 64'd0);
      reset_n = 1'b1;
      gap(2);

      // ---- basic capture: trigger at 0x114, four post records
      for (int i = 0; i < 10; i++)
         q_a.push_back(mk(XW'(32'h100 + 4*i), 2'(i), i == 5, i == 9));
      pulse_arm(0);
      chk("arm_record", 64'(bus_a.state), 64'd1);
      for (int i = 0; i < 10; i++) begin
         retire(XW'(32'h100 + 4*i), 2'(i), i == 5);
         if (i == 5) chk("basic_post_state", 64'(bus_a.state), 64'd2);
      end
      chk("basic_dump_state", 64'(bus_a.state), 64'd3);
      chk("basic_dump_count", 64'(bus_a.count), 64'd10);
      wait_idle("basic", 0);

      // ---- wrap-around with PC-match trigger at i=25
      trig_pc_en = 1'b1; trig_pc = XW'(32'h1064);
      for (int i = 14; i < 30; i++)
         q_a.push_back(mk(XW'(32'h1000 + 4*i), 2'd3, i == 25, i == 29));
      pulse_arm(0);
      for (int i = 0; i < 30; i++) retire(XW'(32'h1000 + 4*i), 2'd3, 1'b0);
      chk("wrap_dump_state", 64'(bus_a.state), 64'd3);
      chk("wrap_dump_count", 64'(bus_a.count), 64'd16);
      trig_pc_en = 1'b0;
      wait_idle("wrap", 0);

      // ---- gaps, second trigger in POST, arm and retirement in DUMP
      q_a.push_back(mk(XW'(32'h300), 2'd3, 1'b0, 1'b0));
      q_a.push_back(mk(XW'(32'h304), 2'd3, 1'b1, 1'b0));
      q_a.push_back(mk(XW'(32'h308), 2'd3, 1'b0, 1'b0));
      q_a.push_back(mk(XW'(32'h30c), 2'd3, 1'b0, 1'b0));
      q_a.push_back(mk(XW'(32'h310), 2'd3, 1'b0, 1'b0));
      q_a.push_back(mk(XW'(32'h314), 2'd3, 1'b0, 1'b1));
      pulse_arm(0);
      retire(XW'(32'h300), 2'd3, 1'b0);
      retire(XW'(32'h304), 2'd3, 1'b1);
      gap(2);
      retire(XW'(32'h308), 2'd3, 1'b0);
      gap(1);
      retire(XW'(32'h30c), 2'd3, 1'b1);
      gap(3);
      chk("gap_post_state", 64'(bus_a.state), 64'd2);
      chk("gap_post_count", 64'(bus_a.count), 64'd4);
      retire(XW'(32'h310), 2'd3, 1'b0);
      chk("gap_still_post", 64'(bus_a.state), 64'd2);
      retire(XW'(32'h314), 2'd3, 1'b0);
      chk("gap_dump_state", 64'(bus_a.state), 64'd3);
      chk("gap_dump_count", 64'(bus_a.count), 64'd6);
      arm_a = 1'b1;
      retire(XW'(32'h318), 2'd3, 1'b1);
      arm_a = 1'b0;
      chk("gap_arm_ignored", 64'(bus_a.state), 64'd3);
      wait_idle("gap", 0);
      gap(3);
      chk("gap_stays_idle", 64'(bus_a.state), 64'd0);

      // ---- POST=0: first record after arm triggers
      q_b.push_back(mk(XW'(32'h4000), 2'd1, 1'b1, 1'b1));
      pulse_arm(1);
      retire(XW'(32'h4000), 2'd1, 1'b1);
      chk("post0_dump_state", 64'(bus_b.state), 64'd3);
      chk("post0_dump_count", 64'(bus_b.count), 64'd1);
      wait_idle("post0", 1);

      // ---- reset asserted while the third record is on the output
      for (int i = 0; i < 3; i++)
         q_a.push_back(mk(XW'(32'h2000 + 4*i), 2'd2, i == 0, 1'b0));
      pulse_arm(0);
      for (int i = 0; i < 5; i++) retire(XW'(32'h2000 + 4*i), 2'd2, i == 0);
      chk("rstdump_state", 64'(bus_a.state), 64'd3);
      tick();
      tick();
      tick();
      chk("rstdump_third_valid", 64'(bus_a.valid), 64'd1);
      #5;
      reset_n = 1'b0;
      #1;
      chk("rstdump_valid_async", 64'(bus_a.valid), 64'd0);
      chk("rstdump_state_async", 64'(bus_a.state), 64'd0);
      chk("rstdump_count_async", 64'(bus_a.count), 64'd0);
      gap(2);
      reset_n = 1'b1;
      gap(1);
      retire(XW'(32'h2100), 2'd3, 1'b1);
      retire(XW'(32'h2104), 2'd3, 1'b1);
      gap(5);
      chk("rstdump_no_rearm", 64'(bus_a.state), 64'd0);
      chk("rstdump_no_output", 64'(q_a.size()), 64'd0);

      // ---- privilege filter (min_prv=3); trigger record has prv 0
      min_prv = 2'd3;
`ifdef YARVI_TRACE_PRV_FILTER_EN
      q_a.push_back(mk(XW'(32'h5000), 2'd3, 1'b0, 1'b0));
      q_a.push_back(mk(XW'(32'h5008), 2'd3, 1'b0, 1'b0));
      q_a.push_back(mk(XW'(32'h500c), 2'd0, 1'b1, 1'b0));
      q_a.push_back(mk(XW'(32'h5014), 2'd3, 1'b0, 1'b0));
      q_a.push_back(mk(XW'(32'h501c), 2'd3, 1'b0, 1'b0));
      q_a.push_back(mk(XW'(32'h5020), 2'd3, 1'b0, 1'b0));
      q_a.push_back(mk(XW'(32'h5024), 2'd3, 1'b0, 1'b1));
`else
      for (int i = 0; i < 8; i++)
         q_a.push_back(mk(XW'(32'h5000 + 4*i), fprv[i], i == 3, i == 7));
`endif
      pulse_arm(0);
      for (int i = 0; i < 10; i++) retire(XW'(32'h5000 + 4*i), fprv[i], i == 3);
      wait_idle("filter", 0);
      min_prv = 2'd0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/yarvi_trace_buf.md
Name: yarvi_trace_buf

Overview:
- Circular retire-trace capture buffer placed directly upstream of the disassembler/trace printer.
- Records the last DEPTH retired instructions (prv, pc, insn, wb_rd, wb_val) from the core's commit stream.
- Freezes after a trigger plus POST further retirements.
- Replays the captured window oldest-first, one record per cycle, on the valid/prv/pc/insn/wb_rd/wb_val/info port set the disassembler consumes.

Parameters:
- DEPTH_LOG2, 4: buffer holds 2**DEPTH_LOG2 records.
- POST, 4: retirements recorded after the trigger record; 0..2**DEPTH_LOG2-1.

Ports:
- clock  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- arm  in  1  one-cycle pulse; starts capture from IDLE.
- trig_ext  in  1  external trigger, sampled only with in_valid.
- trig_pc_en  in  1  enables PC-match trigger.
- trig_pc  in  `VMSB+1  trigger PC.
- min_prv  in  2  privilege filter; used only with the optional feature.
- in_valid  in  1  retirement this cycle.
- in_prv  in  2  privilege level of the retiring instruction.
- in_pc  in  `VMSB+1  retiring PC.
- in_insn  in  32  retiring instruction.
- in_wb_rd  in  5  destination register.
- in_wb_val  in  `VMSB+1  writeback value.
- valid  out  1  replayed record valid.
- prv  out  2  replayed prv.
- pc  out  `VMSB+1  replayed pc.
- insn  out  32  replayed insn.
- wb_rd  out  5  replayed wb_rd.
- wb_val  out  `VMSB+1  replayed wb_val.
- info  out  4  [3] trigger record, [2] last record of dump, [1:0] 0.
- state  out  2  IDLE=0, RECORD=1, POST=2, DUMP=3.
- count  out  DEPTH_LOG2+1  records currently held.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- While reset_n=0:
  - all outputs are 0, state=IDLE, count=0;
  - write/read pointers are 0, post counter is 0.
  - Buffer RAM contents are don't-care.
- Reset asserted mid-operation (any state) aborts immediately; valid drops without waiting for a clock edge.
- IDLE:
  - arm=1 → RECORD; wptr=0, count=0.
  - in_valid is ignored.
- RECORD:
  - Each in_valid cycle writes {prv,pc,insn,wb_rd,wb_val,trig flag} at wptr; wptr+1 mod DEPTH.
  - count increments, saturating at DEPTH. When full, the oldest record is overwritten.
  - Trigger = in_valid & (trig_ext | (trig_pc_en & in_pc==trig_pc)).
  - The triggering record is written with its trig flag set.
  - On trigger: POST=0 → DUMP; else → POST with post counter = POST.
- POST:
  - Each in_valid record is written as in RECORD with trig flag clear; post counter decrements.
  - When the record that brings the counter to 0 is written → DUMP.
  - Further triggers are ignored.
- DUMP:
  - rptr = (wptr - count) mod DEPTH, i.e. the oldest record.
  - From the first edge after entering DUMP, valid=1 for exactly count consecutive cycles.
  - Outputs are registered; records are presented oldest→newest.
  - info[3] = stored trig flag; info[2]=1 on the final record.
  - After the final record: valid=0, state=IDLE, count=0.
  - in_valid retirements during DUMP are dropped.
- arm outside IDLE is ignored. arm and trigger in the same IDLE cycle: arm only; the trigger is not sampled.
- PC compare is full `VMSB+1 width.
- in_valid=0 cycles change nothing in any state.

Optional Feature:
- YARVI_TRACE_PRV_FILTER_EN defined:
  - In RECORD/POST, records with in_prv < min_prv are neither written nor counted toward POST.
  - They can still trigger: the triggering record is written regardless of prv.
- Undefined: min_prv is ignored; all valid retirements are recorded.

Test Plan:
- Basic capture (DEPTH_LOG2=4, POST=4):
  - Stimulus: arm; 10 retirements pc=0x100+4i, i=0..9; trig_ext with pc 0x114.
  - Response: DUMP emits 10 records, pc 0x100..0x124 in order; info[3] only at 0x114; info[2] only at 0x124; then state=IDLE.
- Wrap-around:
  - Stimulus: 30 retirements pc=0x1000+4i; trig_pc_en, trig_pc=0x1064 (i=25).
  - Response: capture ends at i=29; dump emits 16 records, i=14..29; count=16 at DUMP entry.
- Retirement gaps and ignored events:
  - Stimulus: in_valid toggled 1,0,0,1; second trig_ext during POST; arm during DUMP.
  - Response: only valid cycles recorded; post counter unaffected by gaps; second trigger and arm have no effect.
- POST=0 with immediate trigger:
  - Stimulus: first record after arm triggers.
  - Response: DUMP emits exactly 1 record with info=4'b1100.
- Reset mid-dump:
  - Stimulus: reset_n=0 while the 3rd record is being emitted.
  - Response: valid=0 and state=0 without a clock edge. After release, no output until a new arm and trigger.
- With YARVI_TRACE_PRV_FILTER_EN, min_prv=3:
  - Stimulus: mix of prv 0 and 3 records.
  - Response: dump contains only prv=3 records plus the trigger record.
